// File: rtl/ula_slice_sequencer.sv
// Time-multiplexes one external 4-bit ULA slice over an NSLICES*WIDTH-bit word, LSB nibble first.
// Slice carry-out is registered and fed back as the next slice's Cn.
module ula_slice_sequencer #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned NSLICES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [NSLICES*WIDTH-1:0]   req_a,
    input  logic [NSLICES*WIDTH-1:0]   req_b,
    input  logic                       req_m,
    input  logic [3:0]                 req_s,
    input  logic                       req_cin,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [NSLICES*WIDTH-1:0]   res_data,
    output logic                       res_cout,
    output logic                       res_aeqb,
    output logic                       res_zero,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic                       alu_m,
    output logic [3:0]                 alu_s,
    output logic                       alu_cn,
    input  logic [WIDTH-1:0]           alu_f,
    input  logic                       alu_cn4,
    input  logic                       alu_aeqb
);

    localparam int unsigned W    = NSLICES * WIDTH;
    localparam int unsigned IDXW = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDXW-1:0] LastIdx = IDXW'(NSLICES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t            r_state, w_state_next;
    logic [W-1:0]      r_a, r_b, r_data, w_data_next;
    logic              r_m, r_cin, r_carry, r_aeq, r_zero;
    logic [3:0]        r_s;
    logic [IDXW-1:0]   r_idx;
    logic              w_accept, w_step, w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        res_valid    = 1'b0;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = StRun;
                end
            end
            StRun: begin
                w_step = 1'b1;
                if (r_idx == LastIdx) begin
                    w_last       = 1'b1;
                    w_state_next = StDone;
                end
            end
            StDone: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // ULA inputs come only from registers so there is no loop through the external slice.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_m  = 1'b0;
        alu_s  = 4'b0000;
        alu_cn = 1'b0;
        if (r_state == StRun) begin
            alu_a  = r_a[r_idx*WIDTH +: WIDTH];
            alu_b  = r_b[r_idx*WIDTH +: WIDTH];
            alu_m  = r_m;
            alu_s  = r_s;
            alu_cn = (r_idx == '0) ? r_cin : r_carry;
        end
    end

    always_comb begin
        w_data_next = r_data;
        if (w_step) begin
            w_data_next[r_idx*WIDTH +: WIDTH] = alu_f;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= 1'b0;
            r_s     <= 4'b0000;
            r_cin   <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
            r_carry <= 1'b0;
            r_aeq   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= req_a;
                r_b   <= req_b;
                r_m   <= req_m;
                r_s   <= req_s;
                r_cin <= req_cin;
                r_idx <= '0;
                r_aeq <= 1'b1;
            end
            if (w_step) begin
                r_data  <= w_data_next;
                r_carry <= alu_cn4;
                r_aeq   <= r_aeq & alu_aeqb;
                r_idx   <= w_last ? '0 : r_idx + 1'b1;
                if (w_last) begin
                    r_zero <= (w_data_next == '0);
                end
            end
        end
    end

    assign res_data = r_data;
    assign res_cout = r_carry;
    assign res_aeqb = r_aeq;
    assign res_zero = r_zero;

endmodule

// File: tb/tb_ula_slice_sequencer.sv
// Directed bench for ula_slice_sequencer with a behavioural 4-bit ULA slice on the alu_* ports.
// Covers reset, add/carry ripple, logic mode, A=B, back-pressure and mid-operation reset.
module tb_ula_slice_sequencer;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned NSLICES = 4;
    localparam int unsigned W       = WIDTH * NSLICES;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid, req_ready;
    logic [W-1:0]     req_a, req_b;
    logic             req_m;
    logic [3:0]       req_s;
    logic             req_cin;
    logic             res_valid, res_ready;
    logic [W-1:0]     res_data;
    logic             res_cout, res_aeqb, res_zero;
    logic [WIDTH-1:0] alu_a, alu_b, alu_f;
    logic             alu_m, alu_cn, alu_cn4, alu_aeqb;
    logic [3:0]       alu_s;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ula_slice_sequencer #(.WIDTH(WIDTH), .NSLICES(NSLICES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_m     (req_m),
        .req_s     (req_s),
        .req_cin   (req_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_cout  (res_cout),
        .res_aeqb  (res_aeqb),
        .res_zero  (res_zero),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_m     (alu_m),
        .alu_s     (alu_s),
        .alu_cn    (alu_cn),
        .alu_f     (alu_f),
        .alu_cn4   (alu_cn4),
        .alu_aeqb  (alu_aeqb)
    );

    // Slice model: active-high add with Cn as carry-in, a few logic functions, comparator AeqB.
    always_comb begin
        alu_f    = '0;
        alu_cn4  = 1'b0;
        alu_aeqb = (alu_a == alu_b);
        if (!alu_m) begin
            if (alu_s == 4'b1001) begin
                {alu_cn4, alu_f} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0000, alu_cn};
            end
        end else begin
            case (alu_s)
                4'b0000: alu_f = ~alu_a;
                4'b0110: alu_f = alu_a ^ alu_b;
                4'b1011: alu_f = alu_a & alu_b;
                4'b1110: alu_f = alu_a | alu_b;
                default: alu_f = '0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE, step past the accept edge, then scramble the request inputs.
    task automatic start_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic m, input logic [3:0] s, input logic cin);
        req_a     = a;
        req_b     = b;
        req_m     = m;
        req_s     = s;
        req_cin   = cin;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check({tag, "_alu_lo"}, {20'd0, alu_s, alu_b, alu_a}, {20'd0, s, b[3:0], a[3:0]});
        check({tag, "_alu_cn0"}, {31'd0, alu_cn}, {31'd0, cin});
        req_a   = ~a;
        req_b   = ~b;
        req_m   = ~m;
        req_s   = ~s;
        req_cin = ~cin;
    endtask

    task automatic wait_done(input string tag);
        int cnt = 0;
        while (!res_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check({tag, "_latency"}, cnt, NSLICES);
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    logic [W-1:0] held_data;
    logic [2:0]   held_flags;

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_m     = 1'b0;
        req_s     = 4'b0000;
        req_cin   = 1'b0;
        res_ready = 1'b0;

        // 1. Reset
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_data", {16'd0, res_data}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_alu", {18'd0, alu_a, alu_b, alu_m, alu_s, alu_cn}, 32'd0);
        check("rst_flags", {29'd0, res_cout, res_aeqb, res_zero}, 32'd0);

        // 2. Plain add
        start_op("add", 16'h1234, 16'h4321, 1'b0, 4'b1001, 1'b0);
        wait_done("add");
        check("add_data", {16'd0, res_data}, 32'h5555);
        check("add_cout_zero", {30'd0, res_cout, res_zero}, 32'd0);
        release_result();

        // 3. Carry ripples through every slice
        start_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 4'b1001, 1'b0);
        wait_done("ripple");
        check("ripple_data", {16'd0, res_data}, 32'h0000);
        check("ripple_cout_zero", {30'd0, res_cout, res_zero}, 32'h3);
        release_result();

        // Cn on slice 0 adds one
        start_op("cin", 16'h00FF, 16'h0000, 1'b0, 4'b1001, 1'b1);
        wait_done("cin");
        check("cin_data", {16'd0, res_data}, 32'h0100);
        release_result();

        // 4. Logic mode XOR and A=B detection
        start_op("xor", 16'hA5A5, 16'h0F0F, 1'b1, 4'b0110, 1'b1);
        wait_done("xor");
        check("xor_data", {16'd0, res_data}, 32'hAAAA);
        check("xor_cout_aeqb", {30'd0, res_cout, res_aeqb}, 32'd0);
        release_result();

        start_op("eq", 16'h3C3C, 16'h3C3C, 1'b1, 4'b0110, 1'b0);
        wait_done("eq");
        check("eq_aeqb_zero", {30'd0, res_aeqb, res_zero}, 32'h3);
        release_result();

        start_op("neq", 16'h3C3D, 16'h3C3C, 1'b1, 4'b0110, 1'b0);
        wait_done("neq");
        check("neq_aeqb", {31'd0, res_aeqb}, 32'd0);
        check("neq_data", {16'd0, res_data}, 32'h0001);
        release_result();

        // 5. Back-pressure in DONE, then release with a request in the same cycle
        start_op("hold", 16'h1111, 16'h2222, 1'b0, 4'b1001, 1'b0);
        wait_done("hold");
        held_data  = res_data;
        held_flags = {res_cout, res_aeqb, res_zero};
        check("hold_data", {16'd0, held_data}, 32'h3333);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid_ready", {30'd0, res_valid, req_ready}, 32'h2);
            check("hold_stable", {13'd0, res_cout, res_aeqb, res_zero, res_data},
                  {13'd0, held_flags, held_data});
        end
        req_a     = 16'h0F0F;
        req_b     = 16'h00FF;
        req_m     = 1'b1;
        req_s     = 4'b1011;
        req_cin   = 1'b0;
        req_valid = 1'b1;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("release_idle", {30'd0, res_valid, req_ready}, 32'h1);
        tick();
        req_valid = 1'b0;
        check("late_accept", {31'd0, req_ready}, 32'd0);
        wait_done("and");
        check("and_data", {16'd0, res_data}, 32'h000F);
        release_result();

        // 6. Reset while slice 2 is on the ULA
        start_op("abort", 16'hFFFF, 16'h0001, 1'b0, 4'b1001, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_outs", {11'd0, res_valid, res_cout, res_aeqb, res_zero, res_data}, 32'd0);
        check("abort_alu", {18'd0, alu_a, alu_b, alu_m, alu_s, alu_cn}, 32'd0);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NSLICES + 2; i++) begin
            tick();
            check("abort_no_valid", {31'd0, res_valid}, 32'd0);
        end
        start_op("post", 16'h1234, 16'h4321, 1'b0, 4'b1001, 1'b0);
        wait_done("post");
        check("post_data", {16'd0, res_data}, 32'h5555);
        release_result();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
